// File: rtl/seq_adder_n_if.sv
// Start/done handshake bundle between an operand producer and seq_adder_n.
// The master drives the request side, the slave (the adder) drives status and result.
interface seq_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (output start, a, b, ci, input busy, done, sum, co, ovf);
  modport slave  (input start, a, b, ci, output busy, done, sum, co, ovf);
endinterface

// File: rtl/seq_adder_n.sv
// Multi-cycle adder: CHUNK bits of a+b+ci per clock, LSB chunk first,
// with a registered carry linking the chunks like a ripple chain.
module seq_adder_n #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic          clk,
  input  logic          rst,
  seq_adder_n_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb, res, res_nxt, s_ext, sum_q;
  logic             carry, co_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   csum;
  logic             accept, last, msb_cin;

  always_comb begin
    csum    = {1'b0, ra[CHUNK-1:0]} + {1'b0, rb[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    s_ext   = WIDTH'(csum[CHUNK-1:0]);
    // New chunk enters at the top; after N shifts it sits in its final place.
    res_nxt = (res >> CHUNK) | (s_ext << (WIDTH - CHUNK));
    // Carry into the chunk MSB recovered from its sum bit and operand bits.
    msb_cin = csum[CHUNK-1] ^ ra[CHUNK-1] ^ rb[CHUNK-1];
    last    = (cnt == CW'(N - 1));
    accept  = bus.start && (state != RUN);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ra    <= bus.a;
        rb    <= bus.b;
        carry <= bus.ci;
        cnt   <= '0;
      end else if (state == RUN) begin
        ra    <= ra >> CHUNK;
        rb    <= rb >> CHUNK;
        res   <= res_nxt;
        carry <= csum[CHUNK];
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum_q <= res_nxt;
          co_q  <= csum[CHUNK];
          ovf_q <= msb_cin ^ csum[CHUNK];
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: doc/seq_adder_n.md
Name: seq_adder_n

Overview:
Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in CHUNK bits per clock, LSB chunk first. A registered carry links the chunks, in the same way as a ripple chain of full adders. It sits between operand producers and consumers that use a start/done handshake, and replaces wide combinational ripple adders where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits; must be >= 2.
CHUNK, 1, bits added per clock; must divide WIDTH exactly. N = WIDTH/CHUNK is the number of compute cycles.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the block is idle or in the done cycle.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
ci  input  1  carry-in; captured on the accepting edge.
busy  output  1  high while computing (RUN state).
done  output  1  one-cycle pulse; sum/co/ovf are newly valid.
sum  output  WIDTH  registered result, (a+b+ci) mod 2^WIDTH.
co  output  1  unsigned carry-out of the MSB.
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst high at a clk edge): state goes to IDLE; busy, done, sum, co, ovf all go to 0; the internal carry and chunk counter clear. Reset overrides start and aborts a RUN in progress; no done is produced for an aborted operation.
- State machine:
  - IDLE: start=1 captures a, b, ci into internal shift registers, clears the counter to 0 and moves to RUN. start=0 stays in IDLE.
  - RUN: each edge adds the lowest CHUNK bits of both shift registers plus the carry register. The CHUNK result bits go into the result shift register, the carry register updates, and the operands shift right by CHUNK. The counter increments. On the edge that processes chunk N-1, the full result is copied to sum, co and ovf, and the state moves to DONE.
  - DONE: lasts one cycle. If start=1, the new operands are accepted and the state goes to RUN (back-to-back). Otherwise the state goes to IDLE.
- Timing: if start is sampled at edge 0, then busy=1 between edges 0 and N, and done=1 between edges N and N+1. Latency is N edges. Back-to-back throughput is one operation per N+1 cycles.
- start in RUN is ignored. Operands are not re-sampled and no error is flagged.
- busy=0 in the IDLE and DONE states.
- sum, co and ovf change only on the edge that enters DONE, or on reset. They hold between operations and remain stable while a later RUN is in progress.
- Changes to a, b or ci after the accepting edge have no effect on the operation in progress.
- Chunk arithmetic is a (CHUNK+1)-bit add; the chunk's MSB becomes the next carry.
- ovf uses the carry into bit WIDTH-1. For CHUNK>1 this carry is computed inside the last chunk.
- Wrap-around: an all-ones sum plus a carry-in wraps to 0 with co=1.

Test Plan:
1. WIDTH=8, CHUNK=1. Apply rst, then release. -> busy=done=0, sum=8'h00, co=ovf=0. Next, a=8'hFF, b=8'h01, ci=0, start pulsed at edge 0. -> busy high over edges 0-8. done is high only between edges 8 and 9, with sum=8'h00, co=1, ovf=0.
2. Add a=8'h7F, b=8'h01, ci=0. -> sum=8'h80, co=0, ovf=1. Then add a=8'h80, b=8'h80. -> sum=8'h00, co=1, ovf=1.
3. Add a=8'h00, b=8'h00, ci=1. -> sum=8'h01, co=0, ovf=0. Change a/b at edge 3 of the run. -> result is unchanged.
4. Start (a=8'h12, b=8'h34). Hold start high through RUN with different operands. -> exactly one done, sum=8'h46. Re-asserting start in the DONE cycle launches the next operation, with its done 9 edges later.
5. Assert rst at edge 4 of a run. -> busy=0 and sum/co/ovf=0 the next cycle. No done pulse. A following start runs normally.
6. WIDTH=8, CHUNK=4. Add a=8'hF8, b=8'h09, ci=1. -> done between edges 2 and 3, sum=8'h02, co=1, ovf=0.
